// File: rtl/uarttx_fifo_csr.sv
// CSR block for the UART TX core: control, baud divisor, status and a FWFT TX FIFO.
// Optional interrupt logic and the IRQCTRL register are built when UARTTX_IRQ_EN is defined.
module uarttx_fifo_csr #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CLKDIV_W   = 16,
    parameter int unsigned CLKDIV_RST = 868
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_en,
    input  logic                i_wen,
    input  logic [3:0]          i_byteen,
    input  logic [5:0]          i_addr,
    input  logic [31:0]         i_data,
    output logic [31:0]         o_data,
    output logic                o_tx_en,
    output logic                o_tx_rst,
    output logic [CLKDIV_W-1:0] o_clkdiv,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_data_valid,
    input  logic                i_tx_data_ready,
    input  logic                i_tx_state,
    output logic                o_irq
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [1:0]          ctrl_q, ctrl_d;
    logic [CLKDIV_W-1:0] clkdiv_q, clkdiv_d;
    logic [7:0]          last_q, last_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                ovf_q, ovf_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [31:0]         irq_word;

    logic [3:0] word;
    logic       wr, rd, push_req, push_ok, pop, full, empty, tx_rst, tx_en, valid;
    logic       unused_bits;

    assign word     = i_addr[5:2];
    assign wr       = i_en && i_wen;
    assign rd       = i_en && !i_wen;
    assign tx_en    = ctrl_q[0];
    assign tx_rst   = ctrl_q[1];
    assign full     = (level_q == LW'(FIFO_DEPTH));
    assign empty    = (level_q == '0);
    assign valid    = !empty && tx_en && !tx_rst;
    assign push_req = wr && (word == 4'd1) && i_byteen[0];
    // Fullness is judged before any same-cycle pop, so a push into a full FIFO always drops.
    assign push_ok  = push_req && !full && !tx_rst;
    assign pop      = valid && i_tx_data_ready;

    assign o_tx_en         = tx_en;
    assign o_tx_rst        = tx_rst;
    assign o_clkdiv        = clkdiv_q;
    assign o_tx_data       = mem_q[rd_ptr_q];
    assign o_tx_data_valid = valid;
    assign o_data          = rdata_q;
    assign unused_bits     = ^{i_data, i_addr[1:0], i_byteen};

`ifdef UARTTX_IRQ_EN
    logic [7:0] thr_q, thr_d;
    logic       ie_ovf_q, ie_ovf_d, ie_lvl_q, ie_lvl_d, irq_q, irq_d;

    assign irq_word = {16'h0, thr_q, 6'h0, ie_ovf_q, ie_lvl_q};
    assign irq_d    = (ie_lvl_q && (32'(level_q) <= 32'(thr_q))) || (ie_ovf_q && ovf_q);
    assign o_irq    = irq_q;

    always_comb begin
        thr_d    = thr_q;
        ie_ovf_d = ie_ovf_q;
        ie_lvl_d = ie_lvl_q;
        if (wr && (word == 4'd4)) begin
            if (i_byteen[0]) begin
                ie_ovf_d = i_data[1];
                ie_lvl_d = i_data[0];
            end
            if (i_byteen[1]) thr_d = i_data[15:8];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            thr_q    <= '0;
            ie_ovf_q <= 1'b0;
            ie_lvl_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            thr_q    <= thr_d;
            ie_ovf_q <= ie_ovf_d;
            ie_lvl_q <= ie_lvl_d;
            irq_q    <= irq_d;
        end
    end
`else
    assign irq_word = 32'h0;
    assign o_irq    = 1'b0;
`endif

    always_comb begin
        ctrl_d   = ctrl_q;
        clkdiv_d = clkdiv_q;
        last_d   = last_q;
        if (wr) begin
            case (word)
                4'd0: if (i_byteen[0]) ctrl_d = i_data[1:0];
                4'd1: if (i_byteen[0]) last_d = i_data[7:0];
                4'd3: begin
                    for (int i = 0; i < int'(CLKDIV_W); i++) begin
                        if (i_byteen[i/8]) clkdiv_d[i] = i_data[i];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (tx_rst) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_req && full) ovf_d = 1'b1;
            case ({push_ok, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd) begin
            case (word)
                4'd0:    rdata_d = {30'h0, ctrl_q};
                4'd1:    rdata_d = {24'h0, last_q};
                4'd2:    rdata_d = {8'h0, 8'(level_q), 7'h0, i_tx_state, 4'h0,
                                    ovf_q, full, empty, i_tx_data_ready};
                4'd3:    rdata_d = 32'(clkdiv_q);
                4'd4:    rdata_d = irq_word;
                default: rdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_q   <= '0;
            clkdiv_q <= CLKDIV_W'(CLKDIV_RST);
            last_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            clkdiv_q <= clkdiv_d;
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage needs no reset; level and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_data[7:0];
    end

endmodule
